frame_writer: RTL and testbench
===============================

# frame_writer

Fills the 480×270, 24-bit frame memory that the DVI scan-out reads on its port A. It is the write side of the same memory. It takes a byte stream with a valid/ready handshake, assembles each R, G, B byte triplet into one 24-bit pixel and writes it to memory port B at a linear raster address. It sits between the host/loader interface (UART or bus bridge) and the dual-port frame RAM.

## Interface
Parameters:
- `H_ACTIVE`, default 480: pixels per line.
- `V_ACTIVE`, default 270: lines per frame.
- `ADDR_W`, default 17: frame memory address width. Must satisfy H_ACTIVE*V_ACTIVE ≤ 2^ADDR_W.

Ports (clock and reset first):
- `clk`  in  1: system clock. This is the single clock.
- `rst`  in  1: reset, asynchronous and active-high.
- `sof`  in  1: start-of-frame pulse (one cycle). It arms or restarts loading at address 0.
- `din`  in  8: stream byte.
- `din_valid`  in  1: `din` is valid this cycle.
- `din_ready`  out  1: the block accepts `din` this cycle. It is combinational from state and `sof`.
- `WEB`  out  1: frame memory port B write enable.
- `ADDRB`  out  ADDR_W: port B address.
- `DINB`  out  24: port B write data, {R[7:0], G[7:0], B[7:0]}.
- `busy`  out  1: a frame is being loaded.
- `frame_done`  out  1: one-cycle pulse when the last pixel of a frame is written.
- `frame_abort`  out  1: one-cycle pulse when `sof` arrives mid-frame.

## Operation
- A byte is accepted in any cycle where `din_valid && din_ready`.
- `din_ready` = (state ∈ {GET_R, GET_G, GET_B}) && !sof.
- States and transitions:
  - IDLE: `din_ready`=0. On `sof` go to GET_R.
  - GET_R: on accept, latch R and go to GET_G.
  - GET_G: on accept, latch G and go to GET_B.
  - GET_B: on accept, issue the pixel write. Go to DONE if `pix_cnt` = H_ACTIVE*V_ACTIVE−1, otherwise go to GET_R.
  - DONE: `din_ready`=0. On `sof` go to GET_R.
- Pixel counter `pix_cnt` (ADDR_W bits):
  - Cleared by `sof`.
  - Incremented on each B accept.
  - Never exceeds H_ACTIVE*V_ACTIVE−1, so there is no wrap within a frame.
  - Address order is raster: addr = y*H_ACTIVE + x. Pixel 0 is the top-left pixel.
- `sof` behaviour:
  - `sof` in any state clears `pix_cnt`, discards any partial triplet and goes to GET_R.
  - If the state was GET_R/GET_G/GET_B with `pix_cnt`≠0 or a partial triplet held, `frame_abort` pulses the next cycle.
  - A write already registered still completes.
- `sof` together with `din_valid` in the same cycle: `sof` wins. `din_ready` is 0, so the byte is not consumed; upstream presents it again.
- `busy` = state ∈ {GET_R, GET_G, GET_B}.
- Memory writes are fire-and-forget. The RAM accepts one write per cycle, so there is no back-pressure from memory.

## Timing
- Reset values:
  - state IDLE
  - `WEB`=0, `ADDRB`=0, `DINB`=0
  - `pix_cnt`=0
  - `frame_done`=0, `frame_abort`=0
  - R/G latches = 0
- Write latency: if the B byte is accepted at edge N, then `WEB`=1 with `ADDRB`=`pix_cnt`(old) and `DINB`={R,G,B} during cycle N+1.
  - `WEB` is high for exactly one cycle per pixel.
- `frame_done` is asserted in the same cycle as the final `WEB`, with `ADDRB`=H_ACTIVE*V_ACTIVE−1.
- Throughput: one byte per cycle sustained, which gives one pixel write every 3 cycles.
- Gaps in `din_valid` stall the FSM without any state change.
- Asynchronous reset mid-frame:
  - All outputs return to their reset values immediately.
  - A pending write is dropped.
  - The block waits in IDLE for `sof`.

## Structure
- Shared package holds:
  - frame geometry constants H_ACTIVE=480, V_ACTIVE=270, FRAME_PIXELS=129600.
  - the state encoding.
- The scan-out block uses the same geometry constants. Its base stride of 480 is H_ACTIVE.
- A single flat module is the natural structure. The optional sub-module is `rgb_packer`, the byte-to-24-bit assembler holding R/G latches and the phase.

## Test plan
- Reset, then `sof`, then bytes 0x12,0x34,0x56 on consecutive cycles → one cycle later `WEB`=1, `ADDRB`=0, `DINB`=0x123456. `busy`=1 throughout.
- Full frame: 388800 bytes, `din_valid` held high → 129600 writes at addresses 0..129599 in order. `frame_done` pulses with `ADDRB`=129599. State DONE, `din_ready`=0, and extra bytes are not accepted.
- `din_valid` toggled randomly within a frame → written data and addresses are identical to the back-to-back case, and no write occurs while a triplet is incomplete.
- `sof` after 5 bytes (one pixel + R,G) → `frame_abort` pulses. The next triplet 0xAA,0xBB,0xCC is written to `ADDRB`=0 with `DINB`=0xAABBCC.
- `sof` and `din_valid` in the same cycle with `din`=0x77 → `din_ready`=0 that cycle. 0x77 held one more cycle is taken as R of pixel 0.
- `rst` asserted in the cycle after a B accept → `WEB` goes to 0 immediately and that write is not seen. After release the state is IDLE and bytes are refused until `sof`.

Source files
------------

// File: rtl/frame_writer_pkg.sv
// frame_writer_pkg: frame geometry and writer FSM encoding
// shared by the frame writer and the DVI scan-out.
package frame_writer_pkg;

  localparam int H_ACTIVE     = 480;
  localparam int V_ACTIVE     = 270;
  localparam int FRAME_PIXELS = H_ACTIVE * V_ACTIVE;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_GET_R,
    ST_GET_G,
    ST_GET_B,
    ST_DONE
  } fw_state_e;

endpackage

// File: rtl/frame_writer_rgb_packer.sv
// rgb_packer: holds the R and G bytes of the current triplet
// and presents the full 24-bit pixel alongside the B byte.
module rgb_packer (
  input  logic        clk,
  input  logic        rst,
  input  logic        ld_r_i,
  input  logic        ld_g_i,
  input  logic [7:0]  byte_i,
  output logic [23:0] pix_o
);

  logic [7:0] r_q;
  logic [7:0] g_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_q <= '0;
      g_q <= '0;
    end else begin
      if (ld_r_i) r_q <= byte_i;
      if (ld_g_i) g_q <= byte_i;
    end
  end

  assign pix_o = {r_q, g_q, byte_i};

endmodule

// File: rtl/frame_writer.sv
// frame_writer: byte stream to 24-bit pixels, written in raster
// order to frame memory port B.
module frame_writer #(
  parameter int H_ACTIVE = frame_writer_pkg::H_ACTIVE,
  parameter int V_ACTIVE = frame_writer_pkg::V_ACTIVE,
  parameter int ADDR_W   = 17
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sof,
  input  logic [7:0]        din,
  input  logic              din_valid,
  output logic              din_ready,
  output logic              WEB,
  output logic [ADDR_W-1:0] ADDRB,
  output logic [23:0]       DINB,
  output logic              busy,
  output logic              frame_done,
  output logic              frame_abort
);

  import frame_writer_pkg::*;

  localparam logic [ADDR_W-1:0] LAST_PIX =
    ADDR_W'(H_ACTIVE * V_ACTIVE - 1);

  fw_state_e         state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [23:0]       dinb_q, dinb_d;
  logic              web_q, web_d;
  logic              done_q, done_d;
  logic              abort_q, abort_d;
  logic              ld_r, ld_g;
  logic              accept;
  logic [23:0]       pix;

  rgb_packer u_packer (
    .clk    (clk),
    .rst    (rst),
    .ld_r_i (ld_r),
    .ld_g_i (ld_g),
    .byte_i (din),
    .pix_o  (pix)
  );

  assign busy      = (state_q == ST_GET_R) ||
                     (state_q == ST_GET_G) ||
                     (state_q == ST_GET_B);
  assign din_ready = busy && !sof;
  assign accept    = din_valid && din_ready;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    dinb_d  = dinb_q;
    web_d   = 1'b0;
    done_d  = 1'b0;
    abort_d = 1'b0;
    ld_r    = 1'b0;
    ld_g    = 1'b0;
    unique case (1'b1)
      sof: begin
        state_d = ST_GET_R;
        cnt_d   = '0;
        // progress = a pixel written or a partial triplet held
        abort_d = busy &&
                  (cnt_q != '0 || state_q != ST_GET_R);
      end
      accept && state_q == ST_GET_R: begin
        ld_r    = 1'b1;
        state_d = ST_GET_G;
      end
      accept && state_q == ST_GET_G: begin
        ld_g    = 1'b1;
        state_d = ST_GET_B;
      end
      accept && state_q == ST_GET_B: begin
        web_d  = 1'b1;
        addr_d = cnt_q;
        dinb_d = pix;
        if (cnt_q == LAST_PIX) begin
          state_d = ST_DONE;
          done_d  = 1'b1;
        end else begin
          state_d = ST_GET_R;
          cnt_d   = cnt_q + ADDR_W'(1);
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      dinb_q  <= '0;
      web_q   <= 1'b0;
      done_q  <= 1'b0;
      abort_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      dinb_q  <= dinb_d;
      web_q   <= web_d;
      done_q  <= done_d;
      abort_q <= abort_d;
    end
  end

  assign WEB         = web_q;
  assign ADDRB       = addr_q;
  assign DINB        = dinb_q;
  assign frame_done  = done_q;
  assign frame_abort = abort_q;

endmodule

// File: tb/tb_frame_writer.sv
// tb_frame_writer: random byte stream against a byte-count model
// of the frame writer, on a reduced 6x3 frame.
module tb_frame_writer;

  localparam int H    = 6;
  localparam int V    = 3;
  localparam int AW   = 5;
  localparam int NPIX = H * V;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          sof = 1'b0;
  logic [7:0]    din = '0;
  logic          din_valid = 1'b0;
  logic          din_ready;
  logic          WEB;
  logic [AW-1:0] ADDRB;
  logic [23:0]   DINB;
  logic          busy;
  logic          frame_done;
  logic          frame_abort;

  frame_writer #(
    .H_ACTIVE (H),
    .V_ACTIVE (V),
    .ADDR_W   (AW)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .sof         (sof),
    .din         (din),
    .din_valid   (din_valid),
    .din_ready   (din_ready),
    .WEB         (WEB),
    .ADDRB       (ADDRB),
    .DINB        (DINB),
    .busy        (busy),
    .frame_done  (frame_done),
    .frame_abort (frame_abort)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  // model: armed flag plus bytes consumed in the current frame
  bit       m_busy = 1'b0;
  int       m_cnt  = 0;
  bit [7:0] m_r, m_g;
  int       n_wr   = 0;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // called just after a negedge; returns just after the next one
  task automatic cycle(input logic s, input logic v,
                       input logic [7:0] d);
    bit       rdy, acc, e_web, e_done, e_abort;
    int       e_addr;
    bit [23:0] e_data;
    sof = s; din_valid = v; din = d;
    #1;
    rdy = m_busy && !s;
    chk("din_ready", din_ready, rdy);
    acc = v && rdy;
    e_web = 0; e_done = 0; e_abort = 0;
    e_addr = 0; e_data = '0;
    if (s) begin
      e_abort = m_busy && (m_cnt != 0);
      m_busy  = 1'b1;
      m_cnt   = 0;
    end else if (acc) begin
      case (m_cnt % 3)
        0: m_r = d;
        1: m_g = d;
        default: begin
          e_web  = 1'b1;
          e_addr = m_cnt / 3;
          e_data = {m_r, m_g, d};
        end
      endcase
      m_cnt++;
      if (m_cnt == 3 * NPIX) begin
        e_done = 1'b1;
        m_busy = 1'b0;
      end
    end
    @(posedge clk);
    @(negedge clk);
    chk("WEB", WEB, e_web);
    if (e_web) begin
      n_wr++;
      chk("ADDRB", ADDRB, e_addr);
      chk("DINB", DINB, e_data);
    end
    chk("frame_done", frame_done, e_done);
    chk("frame_abort", frame_abort, e_abort);
    chk("busy", busy, m_busy);
  endtask

  initial begin
    int guard;
    repeat (2) @(negedge clk);
    chk("rst_WEB", WEB, 0);
    chk("rst_ADDRB", ADDRB, 0);
    chk("rst_DINB", DINB, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", frame_done, 0);
    chk("rst_abort", frame_abort, 0);
    chk("rst_ready", din_ready, 0);
    rst = 1'b0;

    // idle refuses bytes until sof
    cycle(0, 1, 8'h99);
    cycle(0, 1, 8'h98);

    // first pixel
    cycle(1, 0, 8'h00);
    cycle(0, 1, 8'h12);
    cycle(0, 1, 8'h34);
    cycle(0, 1, 8'h56);
    cycle(0, 0, 8'h00);

    // sof with a byte present: byte retried as R of pixel 0
    cycle(1, 1, 8'h77);
    cycle(0, 1, 8'h77);

    // finish the frame with random gaps
    guard = 0;
    while (m_busy && guard < 2000) begin
      cycle(0, ($urandom % 4) != 0, 8'($urandom));
      guard++;
    end
    chk("frame1_finished", m_busy, 0);

    // DONE refuses extra bytes
    repeat (3) cycle(0, 1, 8'($urandom));

    // back-to-back full frame
    n_wr = 0;
    cycle(1, 0, 8'h00);
    for (int i = 0; i < 3 * NPIX; i++)
      cycle(0, 1, 8'($urandom));
    chk("b2b_writes", n_wr, NPIX);
    cycle(0, 1, 8'h55);

    // abort after one pixel plus R,G
    cycle(1, 0, 8'h00);
    for (int i = 0; i < 5; i++)
      cycle(0, 1, 8'(8'h10 + i));
    cycle(1, 0, 8'h00);
    cycle(0, 1, 8'hAA);
    cycle(0, 1, 8'hBB);
    cycle(0, 1, 8'hCC);

    // reset in the cycle after a B accept
    cycle(0, 1, 8'h01);
    cycle(0, 1, 8'h02);
    sof = 0; din_valid = 1; din = 8'h03;
    #1;
    chk("pre_rst_ready", din_ready, 1);
    @(posedge clk);
    #1 rst = 1'b1;
    #1;
    chk("arst_WEB", WEB, 0);
    chk("arst_ADDRB", ADDRB, 0);
    chk("arst_DINB", DINB, 0);
    chk("arst_busy", busy, 0);
    chk("arst_ready", din_ready, 0);
    din_valid = 0;
    @(negedge clk);
    rst = 1'b0;
    m_busy = 1'b0;
    m_cnt  = 0;
    cycle(0, 1, 8'h44);
    cycle(0, 1, 8'h45);
    cycle(1, 0, 8'h00);
    cycle(0, 1, 8'hDE);
    cycle(0, 1, 8'hAD);
    cycle(0, 1, 8'hBE);
    cycle(0, 0, 8'h00);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
